// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM burst arbiter.
//   arb_state_e : scheduler states (init, arbitrate, refresh, write/read request and busy)
//   GRANT_WR/RD : encoding of the last granted direction; matches the burst_wr polarity
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    StInit,
    StArb,
    StAref,
    StWrReq,
    StWrBusy,
    StRdReq,
    StRdBusy
  } arb_state_e;

  localparam logic GRANT_WR = 1'b1;
  localparam logic GRANT_RD = 1'b0;

endpackage

// File: rtl/frame_addr_ptr.sv
// Frame address pointer for one direction (write or read) of the frame buffer.
//   clk_i, rst_ni  : clock and asynchronous active-low reset
//   load_i         : reload ptr with the frame start address
//   adv_i          : a burst of adv_len_i words has finished; advance the pointer
//   b_addr_i       : frame start address
//   e_addr_i       : frame end address (exclusive)
//   burst_len_i    : nominal burst length
//   adv_len_i      : length of the burst that just finished
//   ptr_o          : start address of the next burst
//   cur_len_o      : nominal length clipped to the words left in the frame
//   frame_end_o    : one-cycle pulse when the pointer wraps back to the frame start
module frame_addr_ptr #(
  parameter int unsigned AddrW = 24,
  parameter int unsigned LenW  = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [AddrW-1:0] e_addr_i,
  input  logic [LenW-1:0]  burst_len_i,
  input  logic [LenW-1:0]  adv_len_i,
  output logic [AddrW-1:0] ptr_o,
  output logic [LenW-1:0]  cur_len_o,
  output logic             frame_end_o
);

  logic [AddrW-1:0] ptr_q;
  logic [AddrW-1:0] remain;
  logic [LenW-1:0]  remain_sat;
  logic [AddrW-1:0] next_ptr;
  logic             frame_end_q;

  // Words left in the frame, saturated to the burst length width (AddrW > LenW).
  always_comb begin
    remain     = e_addr_i - ptr_q;
    remain_sat = (|remain[AddrW-1:LenW]) ? '1 : remain[LenW-1:0];
    cur_len_o  = (burst_len_i < remain_sat) ? burst_len_i : remain_sat;
    next_ptr   = ptr_q + AddrW'(adv_len_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;
      if (load_i) begin
        ptr_q <= b_addr_i;
      end else if (adv_i) begin
        if (next_ptr >= e_addr_i) begin
          ptr_q       <= b_addr_i;
          frame_end_q <= 1'b1;
        end else begin
          ptr_q <= next_ptr;
        end
      end
    end
  end

  assign ptr_o       = ptr_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler between the SD-to-SDRAM write FIFO, the SDRAM-to-HDMI read FIFO and the
// SDRAM command engine. Refresh wins, then an urgent read, then writes and reads alternate.
//   sys_clk, sys_rst_n           : SDRAM-domain clock, asynchronous active-low reset
//   init_end                     : SDRAM initialisation done; no grants while low
//   read_valid                   : display read path enabled
//   wr_b_addr/wr_e_addr          : write frame start / end (exclusive)
//   rd_b_addr/rd_e_addr          : read frame start / end (exclusive)
//   wr_burst_len/rd_burst_len    : nominal burst lengths
//   wr_fifo_level/rd_fifo_level  : write FIFO backlog / read FIFO fill
//   aref_req/aref_en/aref_end    : refresh request (level), grant, completion pulse
//   burst_req/wr/addr/len        : burst command, held until burst_ack
//   burst_ack/burst_end          : command accepted / burst finished pulse
//   frame_wr_end/frame_rd_end    : one-cycle pulse when a frame pointer wraps
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned      ADDR_W       = 24,
  parameter int unsigned      LEN_W        = 10,
  parameter logic [LEN_W-1:0] RD_URGENT_TH = 10'd128,
  parameter logic [LEN_W-1:0] FIFO_DEPTH   = 10'd512
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              read_valid,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [ADDR_W-1:0] wr_e_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic [ADDR_W-1:0] rd_e_addr,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic [LEN_W-1:0]  wr_fifo_level,
  input  logic [LEN_W-1:0]  rd_fifo_level,
  input  logic              aref_req,
  output logic              aref_en,
  input  logic              aref_end,
  output logic              burst_req,
  output logic              burst_wr,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [LEN_W-1:0]  burst_len,
  input  logic              burst_ack,
  input  logic              burst_end,
  output logic              frame_wr_end,
  output logic              frame_rd_end
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0]  cur_wr_len, cur_rd_len;
  logic [LEN_W-1:0]  rd_space;
  logic              ptr_load, wr_adv, rd_adv;
  logic              wr_elig, rd_elig, rd_urgent;
  logic              grant_wr, grant_rd;

  // Pointers are loaded on the INIT exit edge so they are valid on the first ARB cycle.
  assign ptr_load = (state_q == StInit) && init_end;
  // A burst finishing in the same cycle it is accepted still advances the pointer.
  assign wr_adv = burst_end && ((state_q == StWrBusy) || ((state_q == StWrReq) && burst_ack));
  assign rd_adv = burst_end && ((state_q == StRdBusy) || ((state_q == StRdReq) && burst_ack));

  frame_addr_ptr #(
    .AddrW (ADDR_W),
    .LenW  (LEN_W)
  ) u_wr_ptr (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .load_i      (ptr_load),
    .adv_i       (wr_adv),
    .b_addr_i    (wr_b_addr),
    .e_addr_i    (wr_e_addr),
    .burst_len_i (wr_burst_len),
    .adv_len_i   (burst_len),
    .ptr_o       (wr_ptr),
    .cur_len_o   (cur_wr_len),
    .frame_end_o (frame_wr_end)
  );

  frame_addr_ptr #(
    .AddrW (ADDR_W),
    .LenW  (LEN_W)
  ) u_rd_ptr (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .load_i      (ptr_load),
    .adv_i       (rd_adv),
    .b_addr_i    (rd_b_addr),
    .e_addr_i    (rd_e_addr),
    .burst_len_i (rd_burst_len),
    .adv_len_i   (burst_len),
    .ptr_o       (rd_ptr),
    .cur_len_o   (cur_rd_len),
    .frame_end_o (frame_rd_end)
  );

  always_comb begin
    // An over-reported read level means no free space rather than a wrapped huge value.
    rd_space  = (rd_fifo_level >= FIFO_DEPTH) ? '0 : (FIFO_DEPTH - rd_fifo_level);
    // Zero-length bursts (length input 0) are never eligible.
    wr_elig   = (cur_wr_len != '0) && (wr_fifo_level >= cur_wr_len);
    rd_elig   = read_valid && (cur_rd_len != '0) && (rd_space >= cur_rd_len);
    rd_urgent = rd_elig && (rd_fifo_level < RD_URGENT_TH);

    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (rd_urgent) begin
      grant_rd = 1'b1;
    end else if (wr_elig && rd_elig) begin
      if (last_grant_q == GRANT_RD) begin
        grant_wr = 1'b1;
      end else begin
        grant_rd = 1'b1;
      end
    end else if (wr_elig) begin
      grant_wr = 1'b1;
    end else if (rd_elig) begin
      grant_rd = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StInit;
      last_grant_q <= GRANT_RD;
      aref_en      <= 1'b0;
      burst_req    <= 1'b0;
      burst_wr     <= 1'b0;
      burst_addr   <= '0;
      burst_len    <= '0;
    end else begin
      case (state_q)
        StInit: begin
          if (init_end) begin
            state_q <= StArb;
          end
        end
        StArb: begin
          if (!init_end) begin
            state_q <= StInit;
          end else if (aref_req) begin
            aref_en <= 1'b1;
            state_q <= StAref;
          end else if (grant_wr) begin
            burst_req  <= 1'b1;
            burst_wr   <= 1'b1;
            burst_addr <= wr_ptr;
            burst_len  <= cur_wr_len;
            state_q    <= StWrReq;
          end else if (grant_rd) begin
            burst_req  <= 1'b1;
            burst_wr   <= 1'b0;
            burst_addr <= rd_ptr;
            burst_len  <= cur_rd_len;
            state_q    <= StRdReq;
          end
        end
        StAref: begin
          if (aref_end) begin
            aref_en <= 1'b0;
            state_q <= StArb;
          end
        end
        StWrReq, StRdReq: begin
          if (burst_ack) begin
            burst_req <= 1'b0;
            if (burst_end) begin
              last_grant_q <= burst_wr;
              state_q      <= StArb;
            end else begin
              state_q <= burst_wr ? StWrBusy : StRdBusy;
            end
          end
        end
        StWrBusy, StRdBusy: begin
          if (burst_end) begin
            last_grant_q <= burst_wr;
            state_q      <= StArb;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench: stimulus pushes expected grants into a queue, a monitor pops them on
// every rising burst_req / aref_en, and a small command-engine model answers the DUT.
module tb_sdram_burst_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 10;
  localparam logic [1:0]  KAref  = 2'd0;
  localparam logic [1:0]  KWr    = 2'd1;
  localparam logic [1:0]  KRd    = 2'd2;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } grant_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              init_end, read_valid;
  logic [ADDR_W-1:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
  logic [LEN_W-1:0]  wr_burst_len, rd_burst_len, wr_fifo_level, rd_fifo_level;
  logic              aref_req, aref_en, aref_end;
  logic              burst_req, burst_wr, burst_ack, burst_end;
  logic [ADDR_W-1:0] burst_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              frame_wr_end, frame_rd_end;

  grant_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     aref_kicks = 0;
  int     aref_served = 0;
  int     bursts_done = 0;
  int     frame_wr_cnt = 0;
  int     frame_rd_cnt = 0;
  int     busy_cycles = 4;
  bit     same_cycle = 1'b0;
  bit     hold_ack = 1'b0;

  assign aref_req = (aref_kicks != aref_served);

  always #4 sys_clk = ~sys_clk;

  sdram_burst_arbiter dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .init_end      (init_end),
    .read_valid    (read_valid),
    .wr_b_addr     (wr_b_addr),
    .wr_e_addr     (wr_e_addr),
    .rd_b_addr     (rd_b_addr),
    .rd_e_addr     (rd_e_addr),
    .wr_burst_len  (wr_burst_len),
    .rd_burst_len  (rd_burst_len),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_level (rd_fifo_level),
    .aref_req      (aref_req),
    .aref_en       (aref_en),
    .aref_end      (aref_end),
    .burst_req     (burst_req),
    .burst_wr      (burst_wr),
    .burst_addr    (burst_addr),
    .burst_len     (burst_len),
    .burst_ack     (burst_ack),
    .burst_end     (burst_end),
    .frame_wr_end  (frame_wr_end),
    .frame_rd_end  (frame_rd_end)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int addr, input int len);
    grant_t g;
    g.kind = kind;
    g.addr = ADDR_W'(addr);
    g.len  = LEN_W'(len);
    exp_q.push_back(g);
  endtask

  // Monitor: every new grant must match the head of the expectation queue.
  task automatic monitor();
    logic   prev_req = 1'b0;
    logic   prev_aref = 1'b0;
    grant_t got, exp;
    forever begin
      @(negedge sys_clk);
      if (frame_wr_end) frame_wr_cnt++;
      if (frame_rd_end) frame_rd_cnt++;
      if ((burst_req && !prev_req) || (aref_en && !prev_aref)) begin
        if (aref_en && !prev_aref) begin
          got = '{kind: KAref, addr: '0, len: '0};
        end else begin
          got = '{kind: (burst_wr ? KWr : KRd), addr: burst_addr, len: burst_len};
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL grant: got kind=%0d addr=%0h len=%0d, required no grant (t=%0t)",
                   got.kind, got.addr, got.len, $time);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_bad++;
            $display("FAIL grant: got kind=%0d addr=%0h len=%0d, required kind=%0d addr=%0h len=%0d (t=%0t)",
                     got.kind, got.addr, got.len, exp.kind, exp.addr, exp.len, $time);
          end
        end
      end
      prev_req  = burst_req;
      prev_aref = aref_en;
    end
  endtask

  // Command engine model: acks a request at once, ends it busy_cycles later; refresh takes 3.
  task automatic engine();
    int cnt = 0;
    int acnt = 0;
    bit busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      burst_ack = 1'b0;
      burst_end = 1'b0;
      aref_end  = 1'b0;
      if (!sys_rst_n) begin
        busy        = 1'b0;
        cnt         = 0;
        acnt        = 0;
        aref_served = aref_kicks;
        bursts_done = 0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt <= 0) begin
            burst_end = 1'b1;
            busy      = 1'b0;
            bursts_done++;
          end
        end else if (burst_req && !hold_ack) begin
          burst_ack = 1'b1;
          if (same_cycle) begin
            burst_end = 1'b1;
            bursts_done++;
          end else begin
            busy = 1'b1;
            cnt  = busy_cycles;
          end
        end
        if (aref_en) begin
          acnt++;
          if (acnt == 3) begin
            aref_end = 1'b1;
            aref_served++;
            acnt = 0;
          end
        end else begin
          acnt = 0;
        end
      end
    end
  endtask

  task automatic wait_done(input int n, input string what);
    for (int i = 0; i < 400 && bursts_done < n; i++) @(negedge sys_clk);
    check({"bursts done ", what}, 32'(bursts_done), 32'(n));
  endtask

  task automatic wait_req(input string what);
    for (int i = 0; i < 100 && !burst_req; i++) @(negedge sys_clk);
    check({"burst_req seen ", what}, {31'd0, burst_req}, 32'd1);
  endtask

  task automatic rst_on();
    @(negedge sys_clk);
    sys_rst_n    = 1'b0;
    frame_wr_cnt = 0;
    frame_rd_cnt = 0;
  endtask

  task automatic rst_off();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic settle(input string what);
    repeat (12) @(negedge sys_clk);
    check({"queue drained ", what}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0; init_end = 1'b0; read_valid = 1'b1;
    burst_ack = 1'b0; burst_end = 1'b0; aref_end = 1'b0;
    wr_b_addr = 24'h000100; wr_e_addr = 24'h001100;
    rd_b_addr = 24'h200000; rd_e_addr = 24'h201000;
    wr_burst_len = 10'd256; rd_burst_len = 10'd256;
    wr_fifo_level = 10'd300; rd_fifo_level = 10'd0;
    fork
      monitor();
      engine();
    join_none

    // Init hold, then urgent read first, then write; pointers come from the *_b_addr inputs.
    repeat (2) @(negedge sys_clk);
    check("reset burst_req", {31'd0, burst_req}, 32'd0);
    check("reset aref_en", {31'd0, aref_en}, 32'd0);
    check("reset burst_addr", 32'(burst_addr), 32'd0);
    push(KRd, 24'h200000, 256);
    push(KWr, 24'h000100, 256);
    rst_off();
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("no req while init_end low", {31'd0, burst_req}, 32'd0);
    end
    init_end = 1'b1;
    wait_done(1, "urgent read");
    rd_fifo_level = 10'd300;
    wait_done(2, "write after read");
    wr_fifo_level = 10'd0;
    settle("init/urgent");

    // Round robin: write first because last_grant resets to read.
    rst_on();
    wr_b_addr = 0; wr_e_addr = 4096; rd_b_addr = 0; rd_e_addr = 4096;
    wr_fifo_level = 10'd300; rd_fifo_level = 10'd200;
    push(KWr, 0, 256); push(KRd, 0, 256); push(KWr, 256, 256); push(KRd, 256, 256);
    rst_off();
    wait_done(4, "round robin");
    wr_fifo_level = 10'd0; read_valid = 1'b0;
    settle("round robin");

    // Refresh requested while a write is busy: served at the next ARB, then writes resume.
    rst_on();
    wr_fifo_level = 10'd300; busy_cycles = 6;
    push(KWr, 0, 256); push(KAref, 0, 0); push(KWr, 256, 256);
    rst_off();
    for (int i = 0; i < 100 && !burst_ack; i++) @(negedge sys_clk);
    check("ack seen", {31'd0, burst_ack}, 32'd1);
    aref_kicks++;
    wait_done(1, "write before refresh");
    @(negedge sys_clk);
    check("aref_en in ARB cycle", {31'd0, aref_en}, 32'd0);
    @(negedge sys_clk);
    check("aref_en after ARB", {31'd0, aref_en}, 32'd1);
    repeat (2) @(negedge sys_clk);
    check("aref_en held", {31'd0, aref_en}, 32'd1);
    check("aref_end pulse", {31'd0, aref_end}, 32'd1);
    @(negedge sys_clk);
    check("aref_en dropped", {31'd0, aref_en}, 32'd0);
    wait_done(2, "write after refresh");
    wr_fifo_level = 10'd0;
    settle("refresh");

    // 1000-word frame: last burst clipped to 232, one wrap pulse, then back to 0.
    rst_on();
    wr_b_addr = 0; wr_e_addr = 1000; wr_fifo_level = 10'd1023; busy_cycles = 2;
    push(KWr, 0, 256); push(KWr, 256, 256); push(KWr, 512, 256);
    push(KWr, 768, 232); push(KWr, 0, 256);
    rst_off();
    wait_done(5, "frame wrap");
    wr_fifo_level = 10'd0;
    settle("frame wrap");
    check("frame_wr_end pulses", 32'(frame_wr_cnt), 32'd1);
    check("frame_rd_end pulses", 32'(frame_rd_cnt), 32'd0);

    // Zero nominal lengths are never eligible, even with an empty read FIFO.
    rst_on();
    wr_burst_len = 10'd0; rd_burst_len = 10'd0; read_valid = 1'b1;
    wr_fifo_level = 10'd1023; rd_fifo_level = 10'd0;
    rst_off();
    repeat (30) @(negedge sys_clk);
    check("zero length no req", {31'd0, burst_req}, 32'd0);

    // burst_ack and burst_end in the same cycle.
    rst_on();
    wr_burst_len = 10'd128; rd_burst_len = 10'd64; read_valid = 1'b0;
    wr_e_addr = 4096; wr_fifo_level = 10'd300; same_cycle = 1'b1;
    push(KWr, 0, 128); push(KWr, 128, 128);
    rst_off();
    wait_done(2, "same-cycle ack/end");
    wr_fifo_level = 10'd0;
    settle("same-cycle");
    same_cycle = 1'b0;

    // Asynchronous reset while a read request is pending.
    rst_on();
    read_valid = 1'b1; rd_fifo_level = 10'd0; rd_b_addr = 24'h200000; rd_e_addr = 24'h201000;
    hold_ack = 1'b1;
    push(KRd, 24'h200000, 64);
    rst_off();
    wait_req("before reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("async reset burst_req", {31'd0, burst_req}, 32'd0);
    init_end = 1'b0;
    rst_off();
    repeat (10) @(negedge sys_clk);
    check("INIT holds after reset", {31'd0, burst_req}, 32'd0);
    push(KRd, 24'h200000, 64);
    init_end = 1'b1;
    wait_req("after reinit");
    settle("async reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
